fifo_wr_arbiter: RTL

- Shares the single FIFO write port among NUM_REQ producers.
- Each producer uses a valid/ready handshake. Arbitration is round-robin with burst locking.
- Drives fifo write_en/data_in from registers and uses full/almost_full for backpressure, so the FIFO never sees a write while full (overflow never asserts).
- Sits between the producer agents and the fifo instance.

---
 rtl/fifo_arb_pkg.sv | 38 +++
 rtl/rr_select.sv | 32 +++
 rtl/fifo_wr_arbiter.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
// rr_pick works on a fixed 16-wide request vector so one function serves
// every NUM_REQ from 2 to 16; callers zero-pad their inputs.
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    localparam int STAT_WIDTH = 16;
    localparam int MAX_REQ    = 16;
    localparam int MAX_ID_W   = 4;

    typedef struct packed {
        logic                found;
        logic [MAX_ID_W-1:0] idx;
    } rr_pick_t;

    // First set bit at or after ptr, wrapping at num_req (not at a power of 2).
    function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0]  valid,
                                         input logic [MAX_ID_W-1:0] ptr,
                                         input int                  num_req);
        rr_pick_t res;
        int       k;
        res = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            k = int'(ptr) + i;
            if (k >= num_req) k = k - num_req;
            if (i < num_req && !res.found && valid[k[3:0]]) begin
                res.found = 1'b1;
                res.idx   = k[3:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin picker used by the arbiter while idle.
module rr_select
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  valid,
    input  logic [ID_WIDTH-1:0] ptr,
    output logic                found,
    output logic [ID_WIDTH-1:0] idx
);

    logic [MAX_REQ-1:0]  valid_pad;
    logic [MAX_ID_W-1:0] ptr_pad;
    rr_pick_t            pick;
    logic                unused_idx_hi;

    // Pad to the package function's fixed width and scan.
    always_comb begin
        valid_pad                = '0;
        valid_pad[NUM_REQ-1:0]   = valid;
        ptr_pad                  = '0;
        ptr_pad[ID_WIDTH-1:0]    = ptr;
        pick                     = rr_pick(valid_pad, ptr_pad, NUM_REQ);
    end

    assign found         = pick.found;
    assign idx           = pick.idx[ID_WIDTH-1:0];
    assign unused_idx_hi = ^pick.idx;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locked arbiter sharing one FIFO write port among
// NUM_REQ valid/ready producers. Write strobe and data are registered.
// Optional per-requester beat counters: define FIFO_ARB_BEAT_STATS_EN.
//
// state | meaning
// IDLE  | no grant; pick next requester from rr_ptr (one cycle)
// BURST | grant held on grant_id; up to BURST_LEN beats accepted
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 4,
    parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    input  logic                          fifo_almost_full,
    output logic                          fifo_write_en,
    output logic [DATA_WIDTH-1:0]         fifo_data_in,
    output logic                          grant_active,
    output logic [ID_WIDTH-1:0]           grant_id
`ifdef FIFO_ARB_BEAT_STATS_EN
    ,
    input  logic                          stats_clr,
    output logic [NUM_REQ*STAT_WIDTH-1:0] beat_stats
`endif
);

    localparam int                    BEAT_W    = $clog2(BURST_LEN + 1);
    localparam logic [BEAT_W-1:0]     BEAT_LAST = BEAT_W'(BURST_LEN);
    localparam logic [ID_WIDTH-1:0]   ID_LAST   = ID_WIDTH'(NUM_REQ - 1);

    arb_state_t            state_q, state_d;
    logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ID_WIDTH-1:0]   grant_id_q, grant_id_d;
    logic [BEAT_W-1:0]     beat_cnt_q, beat_cnt_d;

    logic                  can_accept;
    logic                  granted_valid;
    logic                  handshake;
    logic                  pick_found;
    logic [ID_WIDTH-1:0]   pick_idx;
    logic [ID_WIDTH-1:0]   ptr_after_grant;

    // A write already registered toward an almost-full FIFO uses the last slot.
    assign can_accept      = !fifo_full && !(fifo_almost_full && fifo_write_en);
    assign granted_valid   = req_valid[grant_id_q];
    assign handshake       = (state_q == BURST) && granted_valid && can_accept;
    assign ptr_after_grant = (grant_id_q == ID_LAST) ? '0 : grant_id_q + ID_WIDTH'(1);

    assign grant_active    = (state_q == BURST);
    assign grant_id        = grant_id_q;

    rr_select #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_rr_select (
        .valid (req_valid),
        .ptr   (rr_ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Next-state, beat counting and per-requester ready.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_id_d = grant_id_q;
        beat_cnt_d = beat_cnt_q;
        req_ready  = '0;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d    = BURST;
                    grant_id_d = pick_idx;
                    beat_cnt_d = '0;
                end
            end
            BURST: begin
                req_ready[grant_id_q] = can_accept;
                if (handshake) begin
                    beat_cnt_d = beat_cnt_q + BEAT_W'(1);
                    if (beat_cnt_d == BEAT_LAST) begin
                        state_d  = IDLE;
                        rr_ptr_d = ptr_after_grant;
                    end
                end else if (!granted_valid && can_accept) begin
                    state_d  = IDLE;
                    rr_ptr_d = ptr_after_grant;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM and arbitration registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // Registered write port: one-cycle latency from handshake, data held otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fifo_write_en <= 1'b0;
            fifo_data_in  <= '0;
        end else begin
            fifo_write_en <= handshake;
            if (handshake) begin
                fifo_data_in <= req_data[grant_id_q*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

`ifdef FIFO_ARB_BEAT_STATS_EN
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_stats
        logic [STAT_WIDTH-1:0] cnt_q;

        // Saturating accepted-beat counter; clear wins over increment.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt_q <= '0;
            end else if (stats_clr) begin
                cnt_q <= '0;
            end else if (handshake && (grant_id_q == ID_WIDTH'(i)) && (cnt_q != '1)) begin
                cnt_q <= cnt_q + STAT_WIDTH'(1);
            end
        end

        assign beat_stats[i*STAT_WIDTH +: STAT_WIDTH] = cnt_q;
    end
`endif

endmodule
